// File: rtl/uart_pkg.sv
// Shared UART constants: frame geometry, bit timing and the TX launch sequencer encoding.
package uart_pkg;
  localparam int DATA_BITS      = 8;
  localparam int CLK_HZ         = 30_000_000;
  localparam int BAUD           = 9600;
  localparam int CYCLES_PER_BIT = 3125;
  localparam int BUSY_TIMEOUT   = 4;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LAUNCH    = 3'd1;
  localparam logic [2:0] HOLD      = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer valid/ready byte channel plus the start/data/busy handshake to the UART transmitter.
interface uart_tx_queue_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;

  modport slave (
    input  in_valid, in_data, tx_busy,
    output in_ready, tx_start, tx_data
  );

  modport master (
    output in_valid, in_data, tx_busy,
    input  in_ready, tx_start, tx_data
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; shared by the UART TX and RX paths.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Guard against over/underflow so callers may issue requests unconditionally.
  assign push_ok = push && (count_q != DEPTH_C);
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue ahead of the UART transmitter: buffers producer bytes and launches them one at a time.
module uart_tx_queue #(
  parameter int DEPTH        = 8,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS,
  parameter int BUSY_TIMEOUT = uart_pkg::BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_queue_if.slave         bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   launch_err
);
  import uart_pkg::*;

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // in_ready follows the registered count, so a pop at full frees space one cycle later.
  assign bus.in_ready = !full;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid && bus.in_ready),
    .wdata (bus.in_data),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = err_q;
    tmr_d      = tmr_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: state_d = HOLD;
      // Transmitter latches parity as tx_start falls; keep tx_data put for that cycle.
      HOLD: begin
        tmr_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
      tmr_q      <= tmr_d;
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign launch_err   = err_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue with a queue-level reference model and a transmitter model.
module tb_uart_tx_queue;
  localparam int DEPTH = 8;
  localparam int TMO   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;
  logic       empty, full, launch_err;

  always #5 clk = ~clk;

  uart_tx_queue_if #(.DATA_BITS(8)) bus ();

  uart_tx_queue #(
    .DEPTH        (DEPTH),
    .DATA_BITS    (8),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .launch_err (launch_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue plus launch timing in edges since the launch.
  logic [7:0] mq[$];
  int         cyc = 0;
  logic       m_start, m_err, m_free, m_seen;
  logic [7:0] m_data;
  int         m_launch, age;
  logic       m_acc, m_go;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_start = 0; m_data = 0; m_err = 0; m_free = 1; m_seen = 0;
    end else begin
      m_acc = bus.in_valid && (mq.size() < DEPTH);
      m_go  = m_free && (mq.size() > 0);
      if (!m_free) begin
        age = cyc - m_launch;
        if (!m_seen) begin
          if (age >= 3) begin
            if (bus.tx_busy) m_seen = 1;
            else if (age >= 2 + TMO) begin m_err = 1; m_free = 1; end
          end
        end else if (!bus.tx_busy) begin
          m_free = 1;
        end
      end
      m_start = m_go;
      if (m_go) begin
        m_data = mq.pop_front(); m_launch = cyc; m_free = 0; m_seen = 0;
      end
      if (m_acc) mq.push_back(bus.in_data);
    end
  end

  // Transmitter model: mode 0 normal random busy, 1 never busy, 2 busy held high.
  int          mode = 0;
  logic        st_prev = 0, fall, dly_on = 0;
  int          dly = 0, blen = 0;
  logic [7:0]  rx_byte[$];
  logic [10:0] rx_frame[$];

  function automatic logic [10:0] frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      bus.tx_busy = 0; dly_on = 0; st_prev = 0;
    end else begin
      fall = st_prev && !bus.tx_start;
      if (fall) begin
        rx_byte.push_back(bus.tx_data);
        rx_frame.push_back(frame(bus.tx_data));
      end
      if (mode == 2) begin
        bus.tx_busy = 1; blen = 1; dly_on = 0;
      end else if (mode == 1) begin
        bus.tx_busy = 0; dly_on = 0;
      end else begin
        if (bus.tx_busy) begin
          if (blen > 1) blen--; else bus.tx_busy = 0;
        end else if (dly_on) begin
          if (dly == 0) begin bus.tx_busy = 1; dly_on = 0; end else dly--;
        end
        if (fall) begin
          dly_on = 1; dly = $urandom_range(0, 2); blen = $urandom_range(1, 4);
        end
      end
      st_prev = bus.tx_start;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  logic prev_start = 0;
  int   pulses = 0;
  int   first_start = -1;

  task automatic cmp_cycle();
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("in_ready", bus.in_ready, mq.size() != DEPTH);
    chk("tx_start", bus.tx_start, m_start);
    chk("tx_data", bus.tx_data, m_data);
    chk("launch_err", launch_err, m_err);
    chk("start_twice", bus.tx_start & prev_start, 0);
    if (bus.tx_start) begin
      pulses++;
      if (first_start < 0) first_start = cyc;
    end
    prev_start = bus.tx_start;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic push_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n = 0;
    bus.in_valid = 1; bus.in_data = b;
    do begin
      acc = bus.in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    bus.in_valid = 0;
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(mq.size() == 0 && m_free && !bus.tx_busy) && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_reached", n < 2000, 1);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int base, push_cyc;

  initial begin
    rst = 1; bus.in_valid = 0; bus.in_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_tx_data", bus.tx_data, 0);
    cmp_cycle();
    rst = 0;

    // Single byte: launch one edge after the push, frame checked on the line
    base = rx_byte.size(); first_start = -1;
    push_byte(8'hA5);
    push_cyc = cyc;
    repeat (20) tick();
    chk("single_latency", first_start - push_cyc, 1);
    chk("single_frame", rx_frame[base], 11'h74A);

    // Burst of three back-to-back bytes
    base = rx_byte.size(); pulses = 0;
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h55);
    wait_idle();
    chk("burst_pulses", pulses, 3);
    chk("burst_b0", rx_byte[base], 8'h00);
    chk("burst_b1", rx_byte[base + 1], 8'hFF);
    chk("burst_b2", rx_byte[base + 2], 8'h55);

    // Fill with the transmitter stuck busy, then release
    base = rx_byte.size(); mode = 2;
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'h80 + 8'(i));
    chk("full_count", count, DEPTH);
    chk("full_flag", full, 1);
    chk("full_ready", bus.in_ready, 0);
    bus.in_valid = 1; bus.in_data = 8'h89;
    repeat (3) tick();
    mode = 0;
    push_byte(8'h89); push_byte(8'h8A);
    wait_idle();
    chk("full_nbytes", rx_byte.size() - base, 11);
    for (int i = 0; i < 11; i++) chk("full_order", rx_byte[base + i], 8'h80 + 8'(i));

    // Wrap-around with random producer gaps
    base = rx_byte.size();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      push_byte(8'(i));
    end
    wait_idle();
    chk("wrap_nbytes", rx_byte.size() - base, 3 * DEPTH);
    for (int i = 0; i < 3 * DEPTH; i++) chk("wrap_order", rx_byte[base + i], 8'(i));

    // Busy timeout, then recovery
    mode = 1;
    push_byte(8'h3C);
    repeat (5) tick();
    chk("tmo_not_yet", launch_err, 0);
    repeat (7) tick();
    chk("tmo_err", launch_err, 1);
    mode = 0;
    push_byte(8'h42);
    wait_idle();
    chk("tmo_next_byte", rx_byte[rx_byte.size() - 1], 8'h42);
    chk("tmo_sticky", launch_err, 1);

    // Reset while waiting for the transmitter with four bytes queued
    mode = 2;
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    repeat (2) tick();
    chk("mid_count", count, 4);
    rst = 1; mode = 0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_start", bus.tx_start, 0);
    chk("mid_rst_data", bus.tx_data, 0);
    chk("mid_rst_err", launch_err, 0);
    rst = 0; pulses = 0;
    repeat (10) tick();
    chk("mid_no_launch", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
